ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester access controller for the 16-bit byte-addressable main RAM. It sits between the CPU bus port and a DMA port (disk/console DMA engines) on one side and the RAM's single `addr/DI/DO/CE_N/WE_N/byte_op` port on the other. It arbitrates between the two requesters, sequences one RAM access at a time through a 3-state FSM, latches read data and returns a one-cycle acknowledge. Byte lane steering stays inside the RAM; this block passes `byte_op` and the full byte address through unchanged.

## Interface
- `CPU_PRIO`, default 0: 0 = round-robin between CPU and DMA; 1 = CPU wins every tie.
- `clk  in  1`: single clock; all state changes on posedge.
- `reset  in  1`: synchronous, active-high.
- `cpu_req  in  1`: CPU access request; held with the fields below stable until `cpu_ack`.
- `cpu_we  in  1`: 1 = write, 0 = read.
- `cpu_byte  in  1`: byte access.
- `cpu_addr  in  16`: byte address.
- `cpu_wdata  in  16`: write data; a byte write uses `[7:0]`.
- `cpu_ack  out  1`: one-cycle completion pulse.
- `cpu_rdata  out  16`: registered read data; for a byte read, the byte is in `[7:0]` and `[15:8]` is 0.
- `dma_req`, `dma_we`, `dma_byte`, `dma_addr[15:0]`, `dma_wdata[15:0]`, `dma_ack`, `dma_rdata[15:0]`: same as the CPU set, for the DMA requester.
- `ram_addr  out  16`: to RAM `addr`.
- `ram_di  out  16`: to RAM `DI`.
- `ram_ce_n  out  1`: to RAM `CE_N`, active-low.
- `ram_we_n  out  1`: to RAM `WE_N`, active-low.
- `ram_byte_op  out  1`: to RAM `byte_op`.
- `ram_do  in  16`: from RAM `DO`; combinational read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if either `req` is high, pick a winner, register its fields into the RAM outputs and the owner flag, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: go to DONE unconditionally.
  - DONE: go to IDLE unconditionally.
- Arbitration when only one `req` is high: that requester wins.
- Arbitration when both are high:
  - `CPU_PRIO=1`: CPU wins.
  - `CPU_PRIO=0`: the requester that was not granted last wins.
- `last_grant` updates only when a grant is issued. Reset value is DMA, so the CPU wins the first tie.
- RAM outputs in ACCESS are all registered:
  - `ram_ce_n=0`, `ram_we_n=~we`.
  - `ram_addr`, `ram_di`, `ram_byte_op` come from the winner's latched fields.
- RAM outputs in IDLE and DONE: `ram_ce_n=1`, `ram_we_n=1`, `ram_addr=0`, `ram_di=0`, `ram_byte_op=0`.
- Reads: `ram_do` is captured into the owner's `rdata` at the edge ending ACCESS. Each `rdata` holds until that requester's next read; writes and the other requester's accesses never change it.
- Writes: the RAM commits at the edge ending ACCESS.
- Acknowledge: the owner's `ack` is registered high for exactly the DONE cycle. The other `ack` stays 0.
- No alignment checking. A word access at an odd address is passed as-is (the RAM ignores `addr[0]` for word ops).
- A losing requester keeps `req` high and is served in the next IDLE. No request is dropped.

## Timing
- Reset values: state IDLE, both `ack=0`, both `rdata=0`, `ram_ce_n=1`, `ram_we_n=1`, `ram_addr=0`, `ram_di=0`, `ram_byte_op=0`, `last_grant=DMA`.
- Request timeline: `req` high at edge T (FSM in IDLE) → ACCESS during T..T+1 → `ack` and `rdata` valid during T+1..T+2.
- Throughput: one access per 3 cycles; minimum request-to-ack is 2 edges.
- Requester rule: on seeing `ack`, update or deassert `req` at the edge ending DONE. `req` still high in the following IDLE cycle is a new request.
- Fields are sampled only at the IDLE edge. Changes during ACCESS or DONE have no effect on the access in flight.
- Reset asserted during ACCESS:
  - Next state is IDLE and no `ack` is issued.
  - A write presented in that cycle still commits, because the RAM has no reset.
  - `rdata` is cleared to 0.
- Reset asserted during DONE: `ack` drops the next cycle and all registers go to reset values.

## Test plan
- CPU word write `addr=0o1000`, `wdata=0o123456`, then a word read of the same address → read `cpu_ack` 2 edges after the read request, `cpu_rdata=0o123456`.
- CPU byte write `0o377` to `0o1001`, then a word read of `0o1000` (after the first scenario) → `0o177456`. Byte read of `0o1001` → `0o000377`.
- `CPU_PRIO=0`, both requesting continuously → grants alternate CPU, DMA, CPU, …; first grant goes to CPU; each ack arrives 3 cycles apart.
- `CPU_PRIO=1`, both requesting continuously → only CPU is served. Drop `cpu_req` → DMA is served in the next IDLE.
- DMA reads `0o500` while CPU writes `0o600` back-to-back → `dma_rdata` holds its value across the CPU access; `cpu_rdata` is unchanged by the write.
- Reset pulsed in the ACCESS cycle of a CPU read → no `cpu_ack`, `cpu_rdata=0`, `ram_ce_n=1` the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester (CPU/DMA) arbiter for the single-port main RAM.
// It runs one access every three cycles and returns registered read data with a one-cycle ack.
module ram_arbiter #(
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_byte,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_di,
  output logic        ram_ce_n,
  output logic        ram_we_n,
  output logic        ram_byte_op,
  input  logic [15:0] ram_do
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        owner_dma;
  logic        last_dma;
  logic        cpu_win;
  logic [15:0] read_value;

  // On a tie the CPU wins under priority mode, otherwise whoever was not granted last.
  always_comb begin
    cpu_win = 1'b0;
    if (cpu_req && !dma_req)
      cpu_win = 1'b1;
    else if (cpu_req && dma_req)
      cpu_win = CPU_PRIO ? 1'b1 : last_dma;
  end

  // Byte reads return the selected byte in the low lane with the high lane cleared.
  always_comb begin
    read_value = ram_do;
    if (ram_byte_op)
      read_value = {8'h00, ram_do[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_dma   <= 1'b0;
      last_dma    <= 1'b1;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata   <= 16'h0000;
      dma_rdata   <= 16'h0000;
      ram_addr    <= 16'h0000;
      ram_di      <= 16'h0000;
      ram_ce_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_byte_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner_dma   <= !cpu_win;
            last_dma    <= !cpu_win;
            ram_ce_n    <= 1'b0;
            ram_we_n    <= cpu_win ? !cpu_we    : !dma_we;
            ram_addr    <= cpu_win ? cpu_addr   : dma_addr;
            ram_di      <= cpu_win ? cpu_wdata  : dma_wdata;
            ram_byte_op <= cpu_win ? cpu_byte   : dma_byte;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM commits writes on this edge; reads are captured into the owner's rdata.
          if (ram_we_n) begin
            if (owner_dma)
              dma_rdata <= read_value;
            else
              cpu_rdata <= read_value;
          end
          cpu_ack     <= !owner_dma;
          dma_ack     <= owner_dma;
          ram_ce_n    <= 1'b1;
          ram_we_n    <= 1'b1;
          ram_addr    <= 16'h0000;
          ram_di      <= 16'h0000;
          ram_byte_op <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance backed by a byte-addressed RAM model,
// plus a CPU-priority instance that shares the same request inputs.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_byte = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;

  logic        cpu_ack, dma_ack, ram_ce_n, ram_we_n, ram_byte_op;
  logic [15:0] cpu_rdata, dma_rdata, ram_addr, ram_di, ram_do;

  logic        p_cpu_ack, p_dma_ack, p_ram_ce_n, p_ram_we_n, p_ram_byte_op;
  logic [15:0] p_cpu_rdata, p_dma_rdata, p_ram_addr, p_ram_di;
  logic [15:0] p_ram_do = 16'h0000;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_cpu_rdata = '0, exp_dma_rdata = '0;
  int          n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic        dma;
    logic        we;
    logic        byte_op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];
  vec_t v;

  ram_arbiter #(.CPU_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_byte(dma_byte), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
    .ram_byte_op(ram_byte_op), .ram_do(ram_do)
  );

  ram_arbiter #(.CPU_PRIO(1'b1)) dut_prio (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_byte(dma_byte), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(p_dma_ack), .dma_rdata(p_dma_rdata),
    .ram_addr(p_ram_addr), .ram_di(p_ram_di), .ram_ce_n(p_ram_ce_n), .ram_we_n(p_ram_we_n),
    .ram_byte_op(p_ram_byte_op), .ram_do(p_ram_do)
  );

  always #5 clk = ~clk;

  // Little-endian RAM model: odd byte is the high lane, word ops ignore addr[0].
  always_comb begin
    ram_do = 16'h0000;
    if (!ram_ce_n && ram_we_n) begin
      if (ram_byte_op)
        ram_do = {8'h00, mem[ram_addr]};
      else
        ram_do = {mem[{ram_addr[15:1], 1'b1}], mem[{ram_addr[15:1], 1'b0}]};
    end
  end

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      if (ram_byte_op) begin
        mem[ram_addr] <= ram_di[7:0];
      end else begin
        mem[{ram_addr[15:1], 1'b0}] <= ram_di[7:0];
        mem[{ram_addr[15:1], 1'b1}] <= ram_di[15:8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %06o, expected %06o at %0t", name, actual, expected, $time);
    end
  endtask

  // One isolated transaction: request, ACCESS-cycle RAM port check, ack two edges later, back to IDLE.
  task automatic applyStimulus(input vec_t t);
    @(posedge clk); #1;
    if (t.dma) begin
      dma_req = 1'b1; dma_we = t.we; dma_byte = t.byte_op; dma_addr = t.addr; dma_wdata = t.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = t.we; cpu_byte = t.byte_op; cpu_addr = t.addr; cpu_wdata = t.wdata;
    end
    @(posedge clk); #1;
    checkOutput("access_ce_n", {15'd0, ram_ce_n}, 16'd0);
    checkOutput("access_we_n", {15'd0, ram_we_n}, {15'd0, !t.we});
    checkOutput("access_addr", ram_addr, t.addr);
    checkOutput("access_di", ram_di, t.wdata);
    checkOutput("access_byte_op", {15'd0, ram_byte_op}, {15'd0, t.byte_op});
    checkOutput("access_no_ack", {14'd0, cpu_ack, dma_ack}, 16'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    if (!t.we) begin
      if (t.dma) exp_dma_rdata = t.exp_rdata;
      else       exp_cpu_rdata = t.exp_rdata;
    end
    checkOutput("done_cpu_ack", {15'd0, cpu_ack}, {15'd0, !t.dma});
    checkOutput("done_dma_ack", {15'd0, dma_ack}, {15'd0, t.dma});
    checkOutput("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    checkOutput("dma_rdata", dma_rdata, exp_dma_rdata);
    @(posedge clk); #1;
    checkOutput("idle_acks", {14'd0, cpu_ack, dma_ack}, 16'd0);
    checkOutput("idle_ce_n", {15'd0, ram_ce_n}, 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'o001000, 16'o123456, 16'o000000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'o001000, 16'o000000, 16'o123456};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'o001001, 16'o000377, 16'o000000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'o001000, 16'o000000, 16'o177456};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'o001001, 16'o000000, 16'o000377};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'o001000, 16'o000000, 16'o000056};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'o000500, 16'o070707, 16'o000000};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'o000500, 16'o000000, 16'o070707};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 16'o000501, 16'o111111, 16'o000000};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 16'o000500, 16'o000000, 16'o111111};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_acks", {12'd0, cpu_ack, dma_ack, p_cpu_ack, p_dma_ack}, 16'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 16'd0);
    checkOutput("rst_dma_rdata", dma_rdata, 16'd0);
    checkOutput("rst_ram_ctl", {13'd0, ram_ce_n, ram_we_n, ram_byte_op}, 16'b110);
    checkOutput("rst_ram_addr", ram_addr, 16'd0);
    checkOutput("rst_ram_di", ram_di, 16'd0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Continuous contention after reset: round-robin alternates from the CPU, priority serves only the CPU.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'o001000;
    dma_req = 1'b1; dma_we = 1'b0; dma_byte = 1'b0; dma_addr = 16'o000500;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      checkOutput("rr_cpu_ack", {15'd0, cpu_ack}, {15'd0, (k % 6) == 2});
      checkOutput("rr_dma_ack", {15'd0, dma_ack}, {15'd0, (k % 6) == 5});
      checkOutput("prio_cpu_ack", {15'd0, p_cpu_ack}, {15'd0, (k % 3) == 2});
      checkOutput("prio_dma_ack", {15'd0, p_dma_ack}, 16'd0);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("prio_dma_served", {14'd0, p_cpu_ack, p_dma_ack}, 16'd1);
    checkOutput("rr_dma_served", {14'd0, cpu_ack, dma_ack}, 16'd1);
    dma_req = 1'b0;
    exp_cpu_rdata = 16'o177456; exp_dma_rdata = 16'o111111;
    checkOutput("rr_cpu_rdata", cpu_rdata, exp_cpu_rdata);
    checkOutput("rr_dma_rdata", dma_rdata, exp_dma_rdata);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a CPU read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'o001000;
    @(posedge clk); #1;
    checkOutput("rst_access_ce_n", {15'd0, ram_ce_n}, 16'd0);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
    checkOutput("rst_access_ack", {14'd0, cpu_ack, dma_ack}, 16'd0);
    checkOutput("rst_access_cpu_rdata", cpu_rdata, 16'd0);
    checkOutput("rst_access_dma_rdata", dma_rdata, 16'd0);
    checkOutput("rst_access_ce_n_after", {15'd0, ram_ce_n}, 16'd1);
    @(posedge clk); #1;
    checkOutput("rst_access_ack_late", {14'd0, cpu_ack, dma_ack}, 16'd0);
    checkOutput("rst_access_idle", {15'd0, ram_ce_n}, 16'd1);

    // Back-to-back: CPU write wins the first tie, then the DMA read.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'o000600; cpu_wdata = 16'o055555;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'o000500;
    @(posedge clk); #1;
    checkOutput("b2b_cpu_addr", ram_addr, 16'o000600);
    checkOutput("b2b_cpu_we_n", {15'd0, ram_we_n}, 16'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    checkOutput("b2b_cpu_ack", {14'd0, cpu_ack, dma_ack}, 16'd2);
    checkOutput("b2b_cpu_rdata", cpu_rdata, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("b2b_dma_addr", ram_addr, 16'o000500);
    @(posedge clk); #1;
    dma_req = 1'b0;
    exp_dma_rdata = 16'o111111;
    checkOutput("b2b_dma_ack", {14'd0, cpu_ack, dma_ack}, 16'd1);
    checkOutput("b2b_dma_rdata", dma_rdata, exp_dma_rdata);
    checkOutput("b2b_cpu_rdata_kept", cpu_rdata, 16'd0);
    @(posedge clk); #1;
    v = '{1'b0, 1'b0, 1'b0, 16'o000600, 16'o000000, 16'o055555};
    applyStimulus(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
